// File: rtl/nios2_pio_out.sv
// Avalon-MM output PIO with DATA/OUTSET/OUTCLEAR access and an optional blink
// prescaler (BLINK_MASK, PERIOD, STATUS) built only when NIOS2_PIO_BLINK_EN is defined.
module nios2_pio_out #(
    parameter int unsigned      WIDTH        = 18,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int unsigned      PW           = 24,
    parameter logic [PW-1:0]    PERIOD_RESET = PW'(12499999)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [2:0] ADDR_PERIOD     = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

    logic             write_en;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    assign write_en     = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        data_next = data_reg;
        if (write_en) begin
            case (address)
                ADDR_DATA:     data_next = wdata;
                ADDR_OUTSET:   data_next = data_reg | wdata;
                ADDR_OUTCLEAR: data_next = data_reg & ~wdata;
                default:       data_next = data_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else begin
            data_reg <= data_next;
        end
    end

`ifdef NIOS2_PIO_BLINK_EN
    logic [WIDTH-1:0] blink_mask;
    logic [PW-1:0]    period;
    logic [PW-1:0]    cnt;
    logic             phase;

    // A PERIOD write restarts the blink cycle and wins over a coincident expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask <= '0;
            period     <= PERIOD_RESET;
            cnt        <= '0;
            phase      <= 1'b1;
        end else begin
            if (write_en && address == ADDR_BLINK_MASK) begin
                blink_mask <= wdata;
            end
            if (write_en && address == ADDR_PERIOD) begin
                period <= writedata[PW-1:0];
                cnt    <= '0;
                phase  <= 1'b1;
            end else if (cnt >= period) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign out_next = data_reg & ~(blink_mask & {WIDTH{~phase}});

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata = 32'(data_reg);
            ADDR_BLINK_MASK: readdata = 32'(blink_mask);
            ADDR_PERIOD:     readdata = 32'(period);
            ADDR_STATUS:     readdata = {31'b0, phase};
            default:         readdata = '0;
        endcase
    end
`else
    localparam int unsigned   unused_pw           = PW;
    localparam logic [PW-1:0] unused_period_reset = PERIOD_RESET;

    assign out_next = data_reg;

    always_comb begin
        readdata = '0;
        if (address == ADDR_DATA) begin
            readdata = 32'(data_reg);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
        end else begin
            out_port <= out_next;
        end
    end

endmodule

// File: tb/tb_nios2_pio_out.sv
// Self-checking bench for nios2_pio_out: elapsed-cycle blink model, directed
// literal checks and randomized register traffic.
`timescale 1ns/100ps
module tb_nios2_pio_out;

    localparam int unsigned      WIDTH = 18;
    localparam int unsigned      PW    = 24;
    localparam logic [WIDTH-1:0] RV    = 18'h155;
    localparam logic [PW-1:0]    PR    = 24'd12499999;
`ifdef NIOS2_PIO_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    localparam logic [31:0] EXP_PERIOD_RST = BLINK ? 32'd12499999 : 32'd0;
    localparam logic [31:0] EXP_STATUS_RST = BLINK ? 32'd1 : 32'd0;
    localparam logic [31:0] EXP_MASK_RB    = BLINK ? 32'h0000FFFF : 32'd0;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    nios2_pio_out #(
        .WIDTH(WIDTH),
        .RESET_VALUE(RV),
        .PW(PW),
        .PERIOD_RESET(PR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    // Model: phase derived from edges elapsed since the last period (re)start.
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    logic [WIDTH-1:0] exp_out;
    logic [PW-1:0]    m_period;
    longint unsigned  m_n;

    function automatic logic m_phase();
        longint unsigned half;
        half = longint'(m_period) + 1;
        return ((m_n / half) % 2) == 0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd1:    return BLINK ? 32'(m_mask) : 32'd0;
            3'd2:    return BLINK ? 32'(m_period) : 32'd0;
            3'd3:    return BLINK ? {31'b0, m_phase()} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data   <= RV;
            m_mask   <= '0;
            m_period <= PR;
            m_n      <= 0;
            exp_out  <= RV;
        end else begin
            exp_out <= m_data & ~(m_mask & {WIDTH{~m_phase()}});
            m_n     <= m_n + 1;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data <= writedata[WIDTH-1:0];
                    3'd1: if (BLINK) m_mask <= writedata[WIDTH-1:0];
                    3'd2: if (BLINK) begin
                        m_period <= writedata[PW-1:0];
                        m_n      <= 0;
                    end
                    3'd4: m_data <= m_data | writedata[WIDTH-1:0];
                    3'd5: m_data <= m_data & ~writedata[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] addr, input logic [31:0] wd);
        @(posedge clk);
        #2;
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("out_port_model", 32'(out_port), 32'(exp_out));
            checkOutput("readdata_model", readdata, exp_read(address));
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        #11;
        checkOutput("reset_out_port", 32'(out_port), 32'(RV));
        address = 3'd2;
        #1 checkOutput("reset_period", readdata, EXP_PERIOD_RST);
        address = 3'd3;
        #1 checkOutput("reset_status", readdata, EXP_STATUS_RST);
        address = 3'd0;
        #9 reset_n = 1'b1;
        chk_en = 1'b1;

        applyStimulus(1, 0, 3'd0, 32'h3FFFF);
        applyStimulus(1, 0, 3'd5, 32'h0000F);
        applyStimulus(0, 1, 3'd0, 32'h0);
        @(negedge clk);
        checkOutput("clear_readback", readdata, 32'h3FFF0);
        checkOutput("clear_out_lag", 32'(out_port), 32'h3FFFF);
        @(negedge clk);
        checkOutput("clear_out", 32'(out_port), 32'h3FFF0);
        applyStimulus(1, 0, 3'd4, 32'h00001);
        applyStimulus(0, 1, 3'd0, 32'h0);
        @(negedge clk);
        checkOutput("set_readback", readdata, 32'h3FFF1);
        @(negedge clk);
        checkOutput("set_out", 32'(out_port), 32'h3FFF1);

        applyStimulus(1, 0, 3'd1, 32'h0000FFFF);
        applyStimulus(0, 1, 3'd1, 32'h0);
        @(negedge clk);
        checkOutput("mask_readback", readdata, EXP_MASK_RB);

`ifdef NIOS2_PIO_BLINK_EN
        applyStimulus(1, 0, 3'd0, 32'hFF);
        applyStimulus(1, 0, 3'd1, 32'h0F);
        applyStimulus(1, 0, 3'd2, 32'd3);
        applyStimulus(0, 1, 3'd3, 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checkOutput("blink_out", 32'(out_port), (((k - 1) / 4) % 2) != 0 ? 32'hF0 : 32'hFF);
            checkOutput("blink_status", readdata, ((k / 4) % 2) != 0 ? 32'd0 : 32'd1);
        end

        applyStimulus(1, 0, 3'd0, 32'h1);
        applyStimulus(1, 0, 3'd1, 32'h1);
        applyStimulus(1, 0, 3'd2, 32'd0);
        applyStimulus(0, 1, 3'd3, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("fast_out_k1", 32'(out_port), 32'h1);
        @(negedge clk);
        checkOutput("fast_out_k2", 32'(out_port), 32'h0);
        applyStimulus(1, 0, 3'd2, 32'd5);
        applyStimulus(0, 1, 3'd3, 32'h0);
        @(negedge clk);
        checkOutput("period_load_status", readdata, 32'd1);
`endif

        applyStimulus(1, 0, 3'd0, 32'h3C0FF);
        applyStimulus(1, 0, 3'd1, 32'h0F0F0);
        applyStimulus(1, 0, 3'd2, 32'd2);
        applyStimulus(0, 1, 3'd0, 32'h0);
        repeat (5) @(posedge clk);
        #3;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #0.5;
        checkOutput("async_reset_out", 32'(out_port), 32'(RV));
        checkOutput("async_reset_data", readdata, 32'(RV));
        #0.5;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        for (int i = 0; i < 800; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
            applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, d);
        end
        applyStimulus(0, 1, 3'd0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
